// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the FIFO controller family: FSM state codes,
// RAM operation codes and a helper that packs the RAM operation.
package fifo_ctrl_pkg;

    // Controller FSM states
    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_INIT   = 3'd1,
        S_IDLE   = 3'd2,
        S_ACTIVE = 3'd3,
        S_ERROR  = 3'd4
    } fsm_state_e;

    // RAM operation codes: bit0 = write, bit1 = read
    localparam logic [1:0] RAM_IDLE = 2'b00;
    localparam logic [1:0] RAM_WR   = 2'b01;
    localparam logic [1:0] RAM_RD   = 2'b10;
    localparam logic [1:0] RAM_WRRD = 2'b11;

    // Build the RAM operation code from the accepted read/write strobes
    function automatic logic [1:0] ram_op(input logic rd, input logic wr);
        logic [1:0] op;
        case ({rd, wr})
            2'b01:   op = RAM_WR;
            2'b10:   op = RAM_RD;
            2'b11:   op = RAM_WRRD;
            default: op = RAM_IDLE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/fifo_flags.sv
// Occupancy flag generator shared by the FIFO controllers.
// Flags are registered from the occupancy and thresholds that the owning
// controller is about to load, so they line up with the registered count.
module fifo_flags
    import fifo_ctrl_pkg::*;
#(
    parameter int ADDR_SIZE = 3,
    parameter int RAM_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic [ADDR_SIZE:0]   count_nxt,
    input  logic [ADDR_SIZE:0]   afull_thr_nxt,
    input  logic [ADDR_SIZE:0]   aempty_thr_nxt,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty
);

    localparam logic [ADDR_SIZE:0] DEPTH_C = (ADDR_SIZE + 1)'(RAM_DEPTH);
    localparam logic [ADDR_SIZE:0] ZERO_C  = '0;

    logic full_r;
    logic empty_r;
    logic almost_full_r;
    logic almost_empty_r;

    // Register the flags from the next occupancy value
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            full_r         <= 1'b0;
            empty_r        <= 1'b1;
            almost_full_r  <= 1'b0;
            almost_empty_r <= 1'b1;
        end else begin
            full_r         <= (count_nxt == DEPTH_C);
            empty_r        <= (count_nxt == ZERO_C);
            almost_full_r  <= (count_nxt >= afull_thr_nxt);
            almost_empty_r <= (count_nxt <= aempty_thr_nxt);
        end
    end

    assign full         = full_r;
    assign empty        = empty_r;
    assign almost_full  = almost_full_r;
    assign almost_empty = almost_empty_r;

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO controller for the 8x4 RAM: converts push/pop requests into RAM
// addresses and operation codes, tracks occupancy and reports flags.
// Build option FIFO_CTRL_ERR_STICKY_EN: an illegal operation latches error
// and parks the FSM in S_ERROR until init; otherwise error is a one-cycle
// pulse and traffic continues.
module fifo_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_SIZE  = 3,
    parameter int RAM_DEPTH  = 2 ** ADDR_SIZE
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic                 init,
    input  logic [ADDR_SIZE:0]   afull_thr,
    input  logic [ADDR_SIZE:0]   aempty_thr,
    input  logic                 push,
    input  logic                 pop,
    output logic                 enable,
    output logic [1:0]           state,
    output logic [ADDR_SIZE-1:0] addr_in,
    output logic [ADDR_SIZE-1:0] addr_out,
    output logic [ADDR_SIZE:0]   count,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic                 error,
    output logic                 valid_out
);

    localparam logic [ADDR_SIZE:0] AFULL_RST_C  = (ADDR_SIZE + 1)'(RAM_DEPTH - 1);
    localparam logic [ADDR_SIZE:0] AEMPTY_RST_C = (ADDR_SIZE + 1)'(1);
    localparam logic [ADDR_SIZE:0] ZERO_CNT_C   = '0;

    // The word width only describes the attached RAM; reject nonsense values
    if (DATA_WIDTH < 1) begin : g_bad_cfg
        $error("fifo_ctrl: DATA_WIDTH must be at least 1");
    end

    fsm_state_e           fsm_r;
    fsm_state_e           fsm_nxt_s;
    logic [ADDR_SIZE-1:0] wr_ptr_r;
    logic [ADDR_SIZE-1:0] rd_ptr_r;
    logic [ADDR_SIZE-1:0] wr_ptr_nxt_s;
    logic [ADDR_SIZE-1:0] rd_ptr_nxt_s;
    logic [ADDR_SIZE:0]   count_r;
    logic [ADDR_SIZE:0]   count_nxt_s;
    logic [ADDR_SIZE:0]   afull_thr_r;
    logic [ADDR_SIZE:0]   aempty_thr_r;
    logic [ADDR_SIZE:0]   afull_thr_nxt_s;
    logic [ADDR_SIZE:0]   aempty_thr_nxt_s;
    logic                 traffic_en_s;
    logic                 flush_s;
    logic                 push_ok_s;
    logic                 pop_ok_s;
    logic                 illegal_s;
    logic                 error_r;
    logic                 error_nxt_s;
    logic                 valid_r;
    logic                 enable_r;
    logic                 full_s;
    logic                 empty_s;

    // Qualify requests: traffic only in IDLE/ACTIVE and never during a flush
    always_comb begin
        traffic_en_s = ((fsm_r == S_IDLE) || (fsm_r == S_ACTIVE)) && !init;
        flush_s      = init && (fsm_r != S_RESET);
        push_ok_s    = traffic_en_s && push && (!full_s || pop);
        pop_ok_s     = traffic_en_s && pop && !empty_s;
        illegal_s    = traffic_en_s && ((push && full_s && !pop) || (pop && empty_s));
    end

    // Next pointers, occupancy and thresholds; a flush clears and reloads
    always_comb begin
        wr_ptr_nxt_s     = wr_ptr_r;
        rd_ptr_nxt_s     = rd_ptr_r;
        count_nxt_s      = count_r;
        afull_thr_nxt_s  = afull_thr_r;
        aempty_thr_nxt_s = aempty_thr_r;
        if (flush_s) begin
            wr_ptr_nxt_s     = '0;
            rd_ptr_nxt_s     = '0;
            count_nxt_s      = '0;
            afull_thr_nxt_s  = afull_thr;
            aempty_thr_nxt_s = aempty_thr;
        end else begin
            wr_ptr_nxt_s = wr_ptr_r + {{(ADDR_SIZE-1){1'b0}}, push_ok_s};
            rd_ptr_nxt_s = rd_ptr_r + {{(ADDR_SIZE-1){1'b0}}, pop_ok_s};
            count_nxt_s  = count_r + {{ADDR_SIZE{1'b0}}, push_ok_s}
                                   - {{ADDR_SIZE{1'b0}}, pop_ok_s};
        end
    end

    // FSM next-state: init always flushes, emptiness selects IDLE vs ACTIVE
    always_comb begin
        fsm_nxt_s = fsm_r;
        case (fsm_r)
            S_RESET: begin
                fsm_nxt_s = S_INIT;
            end
            S_INIT: begin
                if (init) begin
                    fsm_nxt_s = S_INIT;
                end else begin
                    fsm_nxt_s = S_IDLE;
                end
            end
            S_IDLE, S_ACTIVE: begin
                if (init) begin
                    fsm_nxt_s = S_INIT;
`ifdef FIFO_CTRL_ERR_STICKY_EN
                end else if (illegal_s) begin
                    fsm_nxt_s = S_ERROR;
`endif
                end else if (count_nxt_s == ZERO_CNT_C) begin
                    fsm_nxt_s = S_IDLE;
                end else begin
                    fsm_nxt_s = S_ACTIVE;
                end
            end
            S_ERROR: begin
                if (init) begin
                    fsm_nxt_s = S_INIT;
                end else begin
                    fsm_nxt_s = S_ERROR;
                end
            end
            default: begin
                fsm_nxt_s = S_RESET;
            end
        endcase
    end

    // Error reporting: latched until init, or a single-cycle pulse
    always_comb begin
`ifdef FIFO_CTRL_ERR_STICKY_EN
        error_nxt_s = illegal_s || (error_r && !init);
`else
        error_nxt_s = illegal_s;
`endif
    end

    // Controller state registers
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            fsm_r        <= S_RESET;
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            count_r      <= '0;
            afull_thr_r  <= AFULL_RST_C;
            aempty_thr_r <= AEMPTY_RST_C;
            error_r      <= 1'b0;
            valid_r      <= 1'b0;
            enable_r     <= 1'b0;
        end else begin
            fsm_r        <= fsm_nxt_s;
            wr_ptr_r     <= wr_ptr_nxt_s;
            rd_ptr_r     <= rd_ptr_nxt_s;
            count_r      <= count_nxt_s;
            afull_thr_r  <= afull_thr_nxt_s;
            aempty_thr_r <= aempty_thr_nxt_s;
            error_r      <= error_nxt_s;
            valid_r      <= pop_ok_s;
            enable_r     <= (fsm_nxt_s != S_RESET);
        end
    end

    fifo_flags #(
        .ADDR_SIZE (ADDR_SIZE),
        .RAM_DEPTH (RAM_DEPTH)
    ) u_flags (
        .clk            (clk),
        .reset_L        (reset_L),
        .count_nxt      (count_nxt_s),
        .afull_thr_nxt  (afull_thr_nxt_s),
        .aempty_thr_nxt (aempty_thr_nxt_s),
        .full           (full_s),
        .empty          (empty_s),
        .almost_full    (almost_full),
        .almost_empty   (almost_empty)
    );

    assign enable    = enable_r;
    assign state     = ram_op(pop_ok_s, push_ok_s);
    assign addr_in   = wr_ptr_r;
    assign addr_out  = rd_ptr_r;
    assign count     = count_r;
    assign full      = full_s;
    assign empty     = empty_s;
    assign error     = error_r;
    assign valid_out = valid_r;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed self-checking bench for fifo_ctrl (both error build options).
module tb_fifo_ctrl;

    logic       clk;
    logic       reset_L;
    logic       init;
    logic [3:0] afull_thr;
    logic [3:0] aempty_thr;
    logic       push;
    logic       pop;
    logic       enable;
    logic [1:0] state;
    logic [2:0] addr_in;
    logic [2:0] addr_out;
    logic [3:0] count;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic       error;
    logic       valid_out;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    fifo_ctrl u_dut (
        .clk          (clk),
        .reset_L      (reset_L),
        .init         (init),
        .afull_thr    (afull_thr),
        .aempty_thr   (aempty_thr),
        .push         (push),
        .pop          (pop),
        .enable       (enable),
        .state        (state),
        .addr_in      (addr_in),
        .addr_out     (addr_out),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .error        (error),
        .valid_out    (valid_out)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Load thresholds and flush: one cycle with init high, one with it low
    task automatic do_init(input logic [3:0] af, input logic [3:0] ae);
        init       = 1'b1;
        afull_thr  = af;
        aempty_thr = ae;
        cycle();
        init = 1'b0;
        cycle();
    endtask

    task automatic push_n(input int n);
        push = 1'b1;
        for (int k = 0; k < n; k++) cycle();
        push = 1'b0;
    endtask

    initial begin
        reset_L    = 1'b0;
        init       = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        afull_thr  = 4'd0;
        aempty_thr = 4'd0;
        #12;
        // Reset values
        check_eq("rst_count",  count, 0);
        check_eq("rst_empty",  empty, 1);
        check_eq("rst_aempty", almost_empty, 1);
        check_eq("rst_full",   full, 0);
        check_eq("rst_afull",  almost_full, 0);
        check_eq("rst_error",  error, 0);
        check_eq("rst_valid",  valid_out, 0);
        check_eq("rst_enable", enable, 0);
        check_eq("rst_state",  state, 0);
        check_eq("rst_addr_in", addr_in, 0);
        reset_L = 1'b1;
        cycle();                     // S_RESET -> S_INIT
        check_eq("init_enable", enable, 1);

        // Push during init is ignored
        init = 1'b1; afull_thr = 4'd6; aempty_thr = 4'd2; push = 1'b1;
        #1 check_eq("init_state", state, 0);
        cycle();
        check_eq("init_count", count, 0);
        init = 1'b0; push = 1'b0;
        cycle();                     // -> S_IDLE

        // Test 1: three pushes
        for (int i = 0; i < 3; i++) begin
            push = 1'b1;
            #1 check_eq("t1_state", state, 1);
            check_eq("t1_addr_in", addr_in, i);
            cycle();
            check_eq("t1_count", count, i + 1);
            check_eq("t1_empty", empty, 0);
            check_eq("t1_aempty", almost_empty, (i + 1 <= 2) ? 1 : 0);
        end

        // Test 2: fill to 8, then an illegal 9th push
        for (int i = 3; i < 8; i++) begin
            cycle();
            check_eq("t2_count", count, i + 1);
            check_eq("t2_afull", almost_full, (i + 1 >= 6) ? 1 : 0);
            check_eq("t2_full",  full, (i + 1 == 8) ? 1 : 0);
        end
        #1 check_eq("t2_ovf_state", state, 0);
        cycle();
        push = 1'b0;
        check_eq("t2_ovf_error", error, 1);
        check_eq("t2_ovf_count", count, 8);
        check_eq("t2_ovf_wr",    addr_in, 0);
        cycle();
`ifdef FIFO_CTRL_ERR_STICKY_EN
        check_eq("t2_err_sticky", error, 1);
        push = 1'b1; pop = 1'b1;
        #1 check_eq("t2_err_blocked", state, 0);
        push = 1'b0; pop = 1'b0;
        do_init(4'd6, 4'd2);
        check_eq("t2_err_cleared", error, 0);
        push_n(8);
        check_eq("t2_refill", count, 8);
`else
        check_eq("t2_err_pulse", error, 0);
`endif

        // Test 3: push+pop while full
        push = 1'b1; pop = 1'b1;
        #1 check_eq("t3_state", state, 3);
        cycle();
        push = 1'b0; pop = 1'b0;
        check_eq("t3_count", count, 8);
        check_eq("t3_wr",    addr_in, 1);
        check_eq("t3_rd",    addr_out, 1);
        check_eq("t3_valid", valid_out, 1);
        check_eq("t3_error", error, 0);
        cycle();
        check_eq("t3_valid_drop", valid_out, 0);

        // Test 4: drain to 1, then 10 push/pop pairs across the wrap
        pop = 1'b1;
        for (int k = 0; k < 7; k++) cycle();
        pop = 1'b0;
        check_eq("t4_drain_count", count, 1);
        check_eq("t4_drain_rd",    addr_out, 0);
        for (int k = 0; k < 10; k++) begin
            push = 1'b1; pop = 1'b1;
            #1 check_eq("t4_state", state, 3);
            cycle();
            check_eq("t4_count", count, 1);
            check_eq("t4_wr",    addr_in, (k + 2) % 8);
            check_eq("t4_rd",    addr_out, (k + 1) % 8);
            check_eq("t4_error", error, 0);
        end
        push = 1'b0; pop = 1'b0;

        // Test 5: pop on empty, then push+pop on empty
        pop = 1'b1;
        cycle();
        check_eq("t5_empty", empty, 1);
        #1 check_eq("t5_udf_state", state, 0);
        cycle();
        pop = 1'b0;
        check_eq("t5_udf_error", error, 1);
        check_eq("t5_udf_rd",    addr_out, 3);
        check_eq("t5_udf_count", count, 0);
        check_eq("t5_udf_valid", valid_out, 0);
`ifdef FIFO_CTRL_ERR_STICKY_EN
        do_init(4'd6, 4'd2);
`else
        cycle();
        check_eq("t5_err_pulse", error, 0);
`endif
        push = 1'b1; pop = 1'b1;
        #1 check_eq("t5_pp_state", state, 1);
        cycle();
        push = 1'b0; pop = 1'b0;
        check_eq("t5_pp_count", count, 1);
        check_eq("t5_pp_error", error, 1);
`ifdef FIFO_CTRL_ERR_STICKY_EN
        check_eq("t5_pp_wr", addr_in, 1);
`else
        check_eq("t5_pp_wr", addr_in, 4);
`endif

        // Test 6: asynchronous reset mid-stream at count 5
        do_init(4'd6, 4'd2);
        push_n(5);
        push = 1'b1; pop = 1'b1;
        cycle();
        check_eq("t6_pre_count", count, 5);
        check_eq("t6_pre_valid", valid_out, 1);
        #2 reset_L = 1'b0;
        #1;
        check_eq("t6_count",  count, 0);
        check_eq("t6_empty",  empty, 1);
        check_eq("t6_aempty", almost_empty, 1);
        check_eq("t6_valid",  valid_out, 0);
        check_eq("t6_enable", enable, 0);
        check_eq("t6_wr",     addr_in, 0);
        check_eq("t6_rd",     addr_out, 0);
        check_eq("t6_state",  state, 0);
        pop = 1'b0;
        #4 reset_L = 1'b1;
        cycle();                     // S_RESET -> S_INIT, push ignored
        check_eq("t6_post_count", count, 0);
        push = 1'b0;
        do_init(4'd6, 4'd2);
        push_n(2);
        check_eq("t6_resume_count",  count, 2);
        check_eq("t6_resume_aempty", almost_empty, 1);
        check_eq("t6_resume_wr",     addr_in, 2);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
